// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad digit collector producing a 4-digit BCD entry and submit pulse
// Feeds the password comparator; handles clear, idle timeout and alert lockout.
module keypad_entry #(
    parameter int          TIMEOUT_CYC = 50_000_000,
    parameter logic [15:0] BLANK       = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        alert,
    output logic [15:0] display,
    output logic        star,
    output logic [2:0]  digit_cnt,
    output logic        entry_err,
    output logic        timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_SUBMIT,
        S_LOCKED
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic [TW-1:0]   timer_inc;
    logic [15:0]     display_nxt;
    logic [2:0]      cnt_nxt;
    logic            star_nxt;
    logic            err_nxt;
    logic            timeout_nxt;

    logic            is_digit;
    logic            is_star;
    logic            is_hash;
    logic            key_live;
    logic            expire;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_star   = key_valid && (key_code == 4'hA);
    assign is_hash   = key_valid && (key_code == 4'hB);
    assign key_live  = is_digit || is_star || is_hash;
    assign timer_inc = timer + 1'b1;

    // Codes C-F do not count as activity, so they let the idle timer run on.
    assign expire = (state == S_ENTRY) && !key_live &&
                    (timer_inc == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (alert) begin
            state_nxt = S_LOCKED;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_digit) begin
                        state_nxt = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (is_star) begin
                        state_nxt = (digit_cnt == 3'd4) ? S_SUBMIT : S_IDLE;
                    end else if (is_hash || expire) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_SUBMIT: state_nxt = S_IDLE;
                S_LOCKED: state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        display_nxt = display;
        cnt_nxt     = digit_cnt;
        timer_nxt   = '0;
        star_nxt    = 1'b0;
        err_nxt     = 1'b0;
        timeout_nxt = 1'b0;
        if (alert) begin
            display_nxt = BLANK;
            cnt_nxt     = 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_digit) begin
                        display_nxt = {BLANK[15:4], key_code};
                        cnt_nxt     = 3'd1;
                    end else if (is_star) begin
                        err_nxt = 1'b1;
                    end
                end
                S_ENTRY: begin
                    timer_nxt = timer_inc;
                    if (is_digit) begin
                        timer_nxt = '0;
                        if (digit_cnt < 3'd4) begin
                            display_nxt = {display[11:0], key_code};
                            cnt_nxt     = digit_cnt + 3'd1;
                        end
                    end else if (is_star) begin
                        timer_nxt = '0;
                        if (digit_cnt == 3'd4) begin
                            star_nxt = 1'b1;
                        end else begin
                            err_nxt     = 1'b1;
                            display_nxt = BLANK;
                            cnt_nxt     = 3'd0;
                        end
                    end else if (is_hash) begin
                        timer_nxt   = '0;
                        display_nxt = BLANK;
                        cnt_nxt     = 3'd0;
                    end else if (expire) begin
                        timer_nxt   = '0;
                        timeout_nxt = 1'b1;
                        display_nxt = BLANK;
                        cnt_nxt     = 3'd0;
                    end
                end
                default: begin
                    display_nxt = BLANK;
                    cnt_nxt     = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display   <= BLANK;
            digit_cnt <= 3'd0;
            timer     <= '0;
            star      <= 1'b0;
            entry_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            display   <= display_nxt;
            digit_cnt <= cnt_nxt;
            timer     <= timer_nxt;
            star      <= star_nxt;
            entry_err <= err_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - self-checking bench for keypad_entry against a digit-queue model
// Stimulus word: bit8 alert, bit4 key_valid, bits3:0 key_code.
module tb_keypad_entry;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        alert = 1'b0;
    logic [15:0] display;
    logic        star;
    logic [2:0]  digit_cnt;
    logic        entry_err;
    logic        timeout;

    int total = 0;
    int bad = 0;

    int   m_q[$];
    bit   m_locked;
    bit   m_submit;
    int   m_idle;
    bit   m_star, m_err, m_to;

    keypad_entry #(.TIMEOUT_CYC(TO), .BLANK(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alert(alert), .display(display), .star(star), .digit_cnt(digit_cnt),
        .entry_err(entry_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_disp();
        logic [15:0] d = 16'hFFFF;
        foreach (m_q[i]) d = {d[11:0], 4'(m_q[i])};
        return d;
    endfunction

    function automatic logic [21:0] exp_vec();
        return {m_disp(), 3'(m_q.size()), m_star, m_err, m_to};
    endfunction

    function automatic logic [21:0] got_vec();
        return {display, digit_cnt, star, entry_err, timeout};
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_locked = 0; m_submit = 0; m_idle = 0;
        m_star = 0; m_err = 0; m_to = 0;
    endtask

    // Empty queue means no entry in progress; a full queue plus '*' is a submit.
    task automatic m_step(input bit kv, input int kc, input bit al);
        bit dig = kv && kc <= 9;
        bit sub = kv && kc == 10;
        bit clr = kv && kc == 11;
        m_star = 0; m_err = 0; m_to = 0;
        if (al) begin
            m_locked = 1; m_submit = 0; m_q.delete(); m_idle = 0;
        end else if (m_locked || m_submit) begin
            m_locked = 0; m_submit = 0; m_q.delete();
        end else if (m_q.size() == 0) begin
            if (dig) m_q.push_back(kc);
            else if (sub) m_err = 1;
        end else if (dig || sub || clr) begin
            m_idle = 0;
            if (dig && m_q.size() < 4) m_q.push_back(kc);
            if (sub && m_q.size() == 4) begin
                m_submit = 1; m_star = 1;
            end else if (sub) begin
                m_err = 1; m_q.delete();
            end
            if (clr) m_q.delete();
        end else begin
            m_idle++;
            if (m_idle == TO - 1) begin
                m_to = 1; m_q.delete(); m_idle = 0;
            end
        end
    endtask

    task automatic step(input int s);
        @(negedge clk);
        alert = s[8]; key_valid = s[4]; key_code = s[3:0];
        @(posedge clk);
        m_step(s[4], int'(s[3:0]), s[8]);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; key_valid = 1'b0; alert = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (got_vec() !== {16'hFFFF, 3'd0, 3'b000}) begin
            bad++;
            $display("FAIL reset got=%h want=%h", got_vec(), {16'hFFFF, 3'd0, 3'b000});
        end
        do_reset();
    endtask

    task automatic test_submit();
        int seq[$] = '{'h11, 'h12, 'h13, 'h14, 'h1A, 'h00, 'h00};
        foreach (seq[i]) begin
            step(seq[i]);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL submit c%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
            total++;
            if (star !== (i == 4) || (i == 4 && display !== 16'h1234) ||
                (i == 5 && (display !== 16'hFFFF || digit_cnt !== 3'd0))) begin
                bad++;
                $display("FAIL submit_fixed c%0d got star=%b disp=%h cnt=%0d", i, star, display, digit_cnt);
            end
        end
    endtask

    task automatic test_entry_err();
        int seq[$] = '{'h15, 'h16, 'h1A, 'h00, 'h11, 'h12, 'h13, 'h14, 'h15, 'h00};
        foreach (seq[i]) begin
            step(seq[i]);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL entry_err c%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        total++;
        if (display !== 16'h1234 || digit_cnt !== 3'd4) begin
            bad++;
            $display("FAIL overflow_hold got disp=%h cnt=%0d want disp=1234 cnt=4", display, digit_cnt);
        end
        step('h1B);
    endtask

    task automatic test_timeout();
        for (int i = 0; i <= 16; i++) begin
            step(i == 0 ? 'h17 : 'h00);
            total++;
            if (got_vec() !== exp_vec() || timeout !== (i == 15)) begin
                bad++;
                $display("FAIL timeout c%0d got=%h want=%h to=%b", i, got_vec(), exp_vec(), timeout);
            end
        end
        for (int i = 0; i <= 20; i++) begin
            step(i == 0 ? 'h17 : (i == 15 ? 'h13 : (i == 8 ? 'h1D : 'h00)));
            total++;
            if (got_vec() !== exp_vec() || (i <= 15 && i != 8 && timeout !== 1'b0)) begin
                bad++;
                $display("FAIL timeout_rearm c%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        step('h1B);
    endtask

    task automatic test_clear_lock();
        int seq[$] = '{'h19, 'h18, 'h1B, 'h11, 'h12, 'h100, 'h113, 'h11A, 'h00,
                       'h11, 'h12, 'h13, 'h14, 'h1A, 'h00};
        foreach (seq[i]) begin
            step(seq[i]);
            total++;
            if (got_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL clear_lock c%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
            if (i == 2 || i == 6) begin
                total++;
                if (display !== 16'hFFFF || digit_cnt !== 3'd0 || {star, entry_err, timeout} !== 3'b000) begin
                    bad++;
                    $display("FAIL blank_c%0d got disp=%h cnt=%0d", i, display, digit_cnt);
                end
            end
        end
        total++;
        if (display !== 16'hFFFF) begin
            bad++;
            $display("FAIL after_unlock_submit got disp=%h want FFFF", display);
        end
    endtask

    task automatic test_alert_star();
        int seq[$] = '{'h11, 'h12, 'h13, 'h14, 'h11A, 'h115, 'h00, 'h00};
        foreach (seq[i]) begin
            step(seq[i]);
            total++;
            if (got_vec() !== exp_vec() || (i == 4 && (star !== 1'b0 || display !== 16'hFFFF))) begin
                bad++;
                $display("FAIL alert_star c%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_submit();
        int seq[$] = '{'h14, 'h13, 'h12, 'h11, 'h1A};
        foreach (seq[i]) step(seq[i]);
        total++;
        if (star !== 1'b1 || display !== 16'h4321) begin
            bad++;
            $display("FAIL pre_reset got star=%b disp=%h want 1 4321", star, display);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (star !== 1'b0 || display !== 16'hFFFF || digit_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reset_submit got star=%b disp=%h cnt=%0d", star, display, digit_cnt);
        end
        do_reset();
    endtask

    task automatic test_random();
        bit al = 0;
        int s;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 59) == 0) al = ~al;
            s = al ? 'h100 : 0;
            if ((n % 200) < 170 && $urandom_range(0, 2) == 0) begin
                s |= 'h10;
                s |= ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            end
            step(s);
            total++;
            if (got_vec() !== exp_vec() || !$onehot0({star, entry_err, timeout})) begin
                bad++;
                $display("FAIL random n%0d s=%h got=%h want=%h", n, s, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_submit();
        test_entry_err();
        test_timeout();
        test_clear_lock();
        test_alert_star();
        test_reset_submit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
